fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Control-side producer for the EX-stage operand forwarding muxes of the 16-bit pipeline. It keeps a shadow copy of the destination-register and control fields across the ID/EX, EX/MEM and MEM/WB stages. From that state it generates the 2-bit forward_a/forward_b select codes. It also detects load-use hazards, issues a one-cycle stall with bubble insertion, and keeps a saturating stall counter for performance monitoring.

Parameters:
REG_ADDR_W, 4, register specifier width (16 architectural registers; register 0 reads as zero)
CNT_W, 16, stall_count width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
freeze  input  1  global pipeline hold (e.g. memory wait); all state holds
flush  input  1  squash the instruction currently in ID (taken branch/jump)
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  ID source register 1
id_rt  input  REG_ADDR_W  ID source register 2
id_rs_used  input  1  id_rs is actually read
id_rt_used  input  1  id_rt is actually read
id_rd  input  REG_ADDR_W  ID destination register
id_reg_write  input  1  ID instruction writes the register file
id_mem_read  input  1  ID instruction is a load
forward_a  output  2  EX operand-1 select: 10 = EX/MEM ALU result, 01 = writeback data, 00 = register file
forward_b  output  2  EX operand-2 select, same encoding
stall  output  1  hold PC and IF/ID this cycle
stall_count  output  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Shadow stages:
  - ID/EX holds {valid, rs, rt, rs_used, rt_used, rd, reg_write, mem_read}.
  - EX/MEM and MEM/WB each hold {valid, rd, reg_write, mem_read}.
- Reset (rst_n=0 at edge):
  - All shadow valid bits and control bits clear; stall_count = 0.
  - Outputs therefore go to forward_a = forward_b = 00 and stall = 0.
  - Reset mid-stall or mid-flush discards everything.
- Edge update, priority order rst_n > freeze > normal:
  - freeze=1: every register holds; stall_count holds.
  - Normal: MEM/WB <= EX/MEM; EX/MEM <= ID/EX.
  - ID/EX <= bubble (all control bits 0) if flush or stall or !id_valid; otherwise ID/EX <= ID fields.
- Load-use hazard (combinational, from ID/EX and ID inputs):
  - Condition: ID/EX.valid & ID/EX.mem_read & ID/EX.rd != 0 & id_valid & ((id_rs_used & id_rs == ID/EX.rd) | (id_rt_used & id_rt == ID/EX.rd)).
  - stall = condition & !flush. flush wins and stall is forced 0.
  - While freeze=1, stall is still driven from the held state.
- Stall length: exactly one cycle per load-use pair. The bubble follows the load into EX/MEM, so the consumer re-evaluates against a non-load ID/EX.
- stall_count increments by 1 on each edge where stall=1 & freeze=0 & rst_n=1. It saturates at all-ones and does not wrap.
- Forwarding (combinational from registered state only, no input-to-output path), for operand A (same for B with rt/rt_used):
  - 10 if EX/MEM.valid & EX/MEM.reg_write & !EX/MEM.mem_read & EX/MEM.rd != 0 & ID/EX.rs_used & EX/MEM.rd == ID/EX.rs.
  - Otherwise 01 if MEM/WB.valid & MEM/WB.reg_write & MEM/WB.rd != 0 & ID/EX.rs_used & MEM/WB.rd == ID/EX.rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB, so the most recent producer wins.
  - A load in EX/MEM never yields 10, because its ALU result is an address.
  - Code 11 is never produced.
  - A bubble in ID/EX yields 00 on both outputs.
- Latency: forward codes are valid in the same cycle the consumer occupies the EX shadow stage. stall is valid in the same cycle the consumer occupies ID.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> forward_a=forward_b=00, stall=0, stall_count=0.
- ALU chain: ADD r3 then SUB r4,r3,r5 issued back-to-back -> when SUB is in EX, forward_a=10 and forward_b=00. With one independent instruction between them -> forward_a=01.
- Double hazard: ADD r2 then ADD r2 then use r2 as rt -> forward_b=10 (newest producer), never 01.
- Load-use: LW r6 then ADD r7,r6,r1 -> stall=1 for exactly one cycle and stall_count goes 0->1. Next cycle stall=0; when ADD reaches EX, forward_a=01.
- r0 and flush: ADD r0 followed by a use of r0 -> forward 00. LW r6 followed by a dependent instruction with flush=1 in that cycle -> stall=0 and stall_count unchanged.
- Freeze and saturation: freeze=1 for 3 cycles during the load-use stall -> stall held at 1, outputs and stall_count frozen. Separately, preload stall_count to 16'hFFFF and trigger another stall -> stall_count stays 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use hazard control.
// Keeps a shadow of the destination/control fields for ID/EX, EX/MEM and
// MEM/WB, derives the operand bypass selects from that registered state, and
// raises a one-cycle stall (with bubble) when a load feeds the next instruction.

// Per-operand bypass select: the newest producer (EX/MEM) wins over MEM/WB.
module fwd_sel #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  logic                  exm_ok,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  wb_ok,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);
  // Priority mux; code 11 can never be produced.
  always_comb begin
    sel = 2'b00;
    if (src_used && exm_ok && (exm_rd == src))    sel = 2'b10;
    else if (src_used && wb_ok && (wb_rd == src)) sel = 2'b01;
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int STAGES  = 2;  // vld_pipe: [0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
  localparam int NUM_OPS = 2;  // operand A, operand B

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  rs_used;
    logic                  rt_used;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } idex_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } exm_t;

  // Load data and ALU data are bypassed identically from writeback, so the
  // load flag has no consumer past EX/MEM and is not carried further.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } wb_t;

  logic [STAGES:0] vld_pipe;
  idex_t           idex, idex_nxt;
  exm_t            exm;
  wb_t             wb;
  logic            load_use, id_take;
  logic            exm_ok, wb_ok;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_src;
  logic [NUM_OPS-1:0]                 op_used;
  logic [NUM_OPS-1:0][1:0]            op_sel;

  // Load in ID/EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = vld_pipe[0] && idex.mem_read && (idex.rd != '0) && id_valid &&
               ((id_rs_used && (id_rs == idex.rd)) ||
                (id_rt_used && (id_rt == idex.rd)));
  end

  // Flush squashes the consumer, so there is nothing to stall for.
  assign stall   = load_use && !flush;
  assign id_take = id_valid && !flush && !stall;

  // Next ID/EX contents: the ID instruction, or an all-zero bubble.
  always_comb begin
    idex_nxt = '0;
    if (id_take)
      idex_nxt = '{id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write, id_mem_read};
  end

  // Shadow pipeline advance and saturating stall counter; freeze holds all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      idex        <= '0;
      exm         <= '0;
      wb          <= '0;
      stall_count <= '0;
    end else if (!freeze) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], id_take};
      idex     <= idex_nxt;
      exm      <= '{idex.rd, idex.reg_write, idex.mem_read};
      wb       <= '{exm.rd, exm.reg_write};
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  // A load's EX/MEM value is an address, never a bypassable result.
  assign exm_ok = vld_pipe[1] && exm.reg_write && !exm.mem_read && (exm.rd != '0);
  assign wb_ok  = vld_pipe[2] && wb.reg_write && (wb.rd != '0);

  assign op_src  = {idex.rt, idex.rs};
  assign op_used = {idex.rt_used && vld_pipe[0], idex.rs_used && vld_pipe[0]};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .src      (op_src[i]),
      .src_used (op_used[i]),
      .exm_ok   (exm_ok),
      .exm_rd   (exm.rd),
      .wb_ok    (wb_ok),
      .wb_rd    (wb.rd),
      .sel      (op_sel[i])
    );
  end

  assign forward_a = op_sel[0];
  assign forward_b = op_sel[1];
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: a 16-bit-counter instance plus a 3-bit-counter
// instance sharing the same stimulus so counter saturation is reachable.
module tb_fwd_hazard_ctrl;
  typedef struct packed {
    logic       v;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       rsu;
    logic       rtu;
    logic [3:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
    logic [2:0]  cs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, freeze = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [3:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [1:0]  forward_a, forward_b, fa2, fb2;
  logic        stall, st2;
  logic [15:0] stall_count;
  logic [2:0]  cs2;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .forward_a(fa2), .forward_b(fb2), .stall(st2), .stall_count(cs2)
  );

  // Reference state: m[0]=ID/EX, m[1]=EX/MEM, m[2]=MEM/WB, plus counters.
  ins_t m [3];
  int   cnt = 0, cs = 0;
  int   n_vec = 0, n_err = 0;
  exp_t q [$];

  logic [1:0]  s_fa, s_fb;
  logic        s_st;
  logic [15:0] s_cnt;
  logic [2:0]  s_cs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.rs = rs; i.rt = rt; i.rsu = 1'b1; i.rtu = 1'b1; i.rd = rd; i.rw = 1'b1;
    return i;
  endfunction

  function automatic ins_t ld(input logic [3:0] rd, input logic [3:0] rs);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.rs = rs; i.rsu = 1'b1; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '0;
    return i;
  endfunction

  function automatic logic [1:0] mfwd(input logic [3:0] r, input logic u);
    if (!m[0].v || !u) return 2'b00;
    if (m[1].v && m[1].rw && !m[1].mr && m[1].rd != 4'd0 && m[1].rd == r) return 2'b10;
    if (m[2].v && m[2].rw && m[2].rd != 4'd0 && m[2].rd == r) return 2'b01;
    return 2'b00;
  endfunction

  // One cycle: drive ID inputs, push expectation, compare mid-cycle, advance model.
  task automatic apply(input ins_t i, input logic fl, input logic fz, input logic rs);
    exp_t e;
    logic st;
    rst_n = rs; flush = fl; freeze = fz;
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rs_used = i.rsu; id_rt_used = i.rtu;
    id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr;
    st = m[0].v && m[0].mr && (m[0].rd != 4'd0) && i.v &&
         ((i.rsu && i.rs == m[0].rd) || (i.rtu && i.rt == m[0].rd)) && !fl;
    e.fa  = mfwd(m[0].rs, m[0].rsu);
    e.fb  = mfwd(m[0].rt, m[0].rtu);
    e.st  = st;
    e.cnt = cnt[15:0];
    e.cs  = cs[2:0];
    q.push_back(e);
    @(negedge clk);
    s_fa = forward_a; s_fb = forward_b; s_st = stall; s_cnt = stall_count; s_cs = cs2;
    e = q.pop_front();
    chk("fwd_a", 32'(s_fa), 32'(e.fa));
    chk("fwd_b", 32'(s_fb), 32'(e.fb));
    chk("stall", 32'(s_st), 32'(e.st));
    chk("stall_count", 32'(s_cnt), 32'(e.cnt));
    chk("sat_count", 32'(s_cs), 32'(e.cs));
    chk("sat_outs", 32'({fa2, fb2, st2}), 32'({e.fa, e.fb, e.st}));
    @(posedge clk);
    if (!rs) begin
      for (int k = 0; k < 3; k++) m[k] = '0;
      cnt = 0; cs = 0;
    end else if (!fz) begin
      if (st) begin
        if (cnt < 65535) cnt++;
        if (cs < 7) cs++;
      end
      m[2] = m[1];
      m[1] = m[0];
      m[0] = (fl || st || !i.v) ? '0 : i;
    end
    #1;
  endtask

  initial begin
    ins_t r;
    for (int k = 0; k < 3; k++) m[k] = '0;

    // Reset held for two edges with random ID inputs
    id_valid = 1'b1; id_rs = 4'($urandom); id_rt = 4'($urandom); id_rd = 4'($urandom);
    id_rs_used = 1'b1; id_rt_used = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply(ld(4'($urandom), 4'($urandom)), 1'b0, 1'b0, 1'b0);
    chk("rst_fa", 32'(s_fa), 32'd0);
    chk("rst_fb", 32'(s_fb), 32'd0);
    chk("rst_stall", 32'(s_st), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);

    // ALU chain back-to-back, then with one independent instruction between
    apply(alu(4'd3, 4'd1, 4'd2), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd4, 4'd3, 4'd5), 1'b0, 1'b0, 1'b1);
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("chain_fa_10", 32'(s_fa), 32'd2);
    chk("chain_fb_00", 32'(s_fb), 32'd0);
    apply(alu(4'd3, 4'd1, 4'd2), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd9, 4'd1, 4'd1), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd4, 4'd3, 4'd5), 1'b0, 1'b0, 1'b1);
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("gap_fa_01", 32'(s_fa), 32'd1);

    // Two producers of r2: newest wins
    apply(alu(4'd2, 4'd1, 4'd1), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd2, 4'd3, 4'd3), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd8, 4'd1, 4'd2), 1'b0, 1'b0, 1'b1);
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("double_fb_10", 32'(s_fb), 32'd2);

    // Load-use: one stall cycle, then writeback forward
    apply(ld(4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    chk("lu_stall", 32'(s_st), 32'd1);
    chk("lu_cnt0", 32'(s_cnt), 32'd0);
    apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    chk("lu_unstall", 32'(s_st), 32'd0);
    chk("lu_cnt1", 32'(s_cnt), 32'd1);
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("lu_fa_01", 32'(s_fa), 32'd1);

    // r0 never forwards
    apply(alu(4'd0, 4'd1, 4'd1), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd9, 4'd0, 4'd0), 1'b0, 1'b0, 1'b1);
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("r0_fa", 32'(s_fa), 32'd0);
    chk("r0_fb", 32'(s_fb), 32'd0);

    // Flush beats the load-use stall
    apply(ld(4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    apply(alu(4'd7, 4'd6, 4'd1), 1'b1, 1'b0, 1'b1);
    chk("flush_stall", 32'(s_st), 32'd0);
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("flush_cnt", 32'(s_cnt), 32'd1);

    // Freeze during a load-use stall
    apply(ld(4'd6, 4'd2), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b1, 1'b1);
      chk("frz_stall", 32'(s_st), 32'd1);
      chk("frz_cnt", 32'(s_cnt), 32'd1);
    end
    apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    chk("frz_release_stall", 32'(s_st), 32'd1);
    apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    chk("frz_after_cnt", 32'(s_cnt), 32'd2);

    // Drive the 3-bit counter past all-ones
    for (int k = 0; k < 6; k++) begin
      apply(ld(4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
      apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
      apply(alu(4'd7, 4'd6, 4'd1), 1'b0, 1'b0, 1'b1);
    end
    apply(nop(), 1'b0, 1'b0, 1'b1);
    chk("sat_hold_7", 32'(s_cs), 32'd7);
    chk("cnt_8", 32'(s_cnt), 32'd8);

    // Random traffic over a small register set
    for (int k = 0; k < 400; k++) begin
      r     = '0;
      r.v   = ($urandom_range(0, 7) != 0);
      r.rs  = 4'($urandom_range(0, 3));
      r.rt  = 4'($urandom_range(0, 3));
      r.rsu = 1'($urandom_range(0, 1));
      r.rtu = 1'($urandom_range(0, 1));
      r.rd  = 4'($urandom_range(0, 3));
      r.rw  = ($urandom_range(0, 3) != 0);
      r.mr  = r.rw && ($urandom_range(0, 2) == 0);
      apply(r, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
